ram_sp_fifo_ctrl: RTL and testbench
===================================

Name: ram_sp_fifo_ctrl

Overview:
- FIFO controller that turns the 16 x 8 single-port RAM (synchronous write, asynchronous read) into a valid/ready byte stream buffer.
- Sits directly upstream of the RAM and drives its address, data_in and write_en pins.
- The RAM data_out is consumed through a registered output stage.
- The single RAM port is arbitrated each cycle between a write (push) and a read-fetch into the output register.

Parameters:
- DATA_W, 8: word width; must match the RAM word.
- ADDR_W, 4: RAM address width.
- DEPTH, 16: RAM locations; must equal 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- s_data  input  DATA_W  push data
- s_valid  input  1  push request
- s_ready  output  1  controller accepts s_data this cycle
- m_data  output  DATA_W  head-of-FIFO word (registered)
- m_valid  output  1  m_data holds a valid word
- m_ready  input  1  consumer takes m_data this cycle
- ram_address  output  ADDR_W  to RAM address
- ram_data_in  output  DATA_W  to RAM data_in
- ram_write_en  output  1  to RAM write_en
- ram_data_out  input  DATA_W  from RAM data_out (combinational read)
- level  output  ADDR_W+1  words held = RAM count + m_valid; range 0..DEPTH+1

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- State:
  - wr_ptr, rd_ptr (ADDR_W bits each; wrap modulo DEPTH).
  - cnt (ADDR_W+1 bits; words resident in RAM, 0..DEPTH).
  - Output register: m_data, m_valid.
- Reset values: wr_ptr=0, rd_ptr=0, cnt=0, m_valid=0, m_data=0. While rst=1, s_ready=0, so ram_write_en=0. RAM contents are not cleared and are don't-care.
- Reset mid-operation discards all stored words. Operation resumes on the first clk edge after rst deasserts.
- fetch (combinational) = (cnt!=0) && (!m_valid || m_ready).
- Port arbitration: fetch has priority over push.
  - s_ready = !rst && (cnt<DEPTH) && !fetch.
  - s_ready depends combinationally on m_ready; the upstream must not gate s_valid on s_ready.
- RAM drive:
  - ram_address = fetch ? rd_ptr : wr_ptr.
  - ram_data_in = s_data.
  - ram_write_en = s_valid && s_ready.
- On a fetch edge:
  - m_data <= ram_data_out, m_valid <= 1.
  - rd_ptr += 1, cnt -= 1.
- On a push edge (s_valid && s_ready): wr_ptr += 1, cnt += 1. Push and fetch are never in the same cycle.
- Consume without fetch (m_valid && m_ready && cnt==0, bypass not taken): m_valid <= 0.
- Latency: a word pushed at edge N is written to RAM at N. It is fetched at edge N+1 at the earliest and is visible on m_data after edge N+1.
- Throughput: with s_valid and m_ready held high, steady-state rate is 1 word per 2 cycles (port alternates push/fetch).
- Full: cnt==DEPTH, so s_ready=0. The output register still holds one extra word, giving total capacity DEPTH+1.
- Empty: cnt==0 and m_valid==0; m_data holds its last value.
- Order is strictly FIFO across pointer wrap (15 -> 0).
- level updates on the same edge as cnt and m_valid.

Optional Feature:
- Macro: RAM_SP_FIFO_BYPASS_EN.
- With the macro defined:
  - When cnt==0, (!m_valid || m_ready) and s_valid=1, the word skips the RAM: m_data <= s_data, m_valid <= 1.
  - s_ready=1, ram_write_en=0, pointers and cnt unchanged.
  - Empty-FIFO latency is 1 edge.
- Without the macro: every word passes through the RAM, with the latency given above.

Test Plan:
1. Reset: assert rst mid-cycle with no clk edge -> immediately m_valid=0, s_ready=0, level=0, ram_write_en=0. Deassert -> s_ready=1.
2. Fill: m_ready=0, push 0x01..0x11 (17 words).
   - First 0x01 lands in the output register.
   - The rest fill the RAM at addresses 1..15 then 0; capacity is 17 as cnt fills to 16.
   - level reaches 17 and s_ready=0. An 18th word 0x12 is held, not accepted.
3. Drain: after the fill, m_ready=1 -> m_data sequence 0x01..0x11 one per cycle, wrap intact, then m_valid=0 and level=0.
4. Streaming: s_valid=1 with incrementing data, m_ready=1 for 40 cycles -> ram_write_en and the fetch address alternate, output rate is 1 word/2 cycles, no loss or duplication.
5. Backpressure and reset: random m_ready toggling with 10 words pushed, then rst pulsed after 5 outputs -> level=0 immediately. Pushing 0xA5 afterwards returns 0xA5 first.
6. Bypass (RAM_SP_FIFO_BYPASS_EN defined), empty FIFO: push 0x3C -> m_valid=1 with m_data=0x3C after 1 edge, and ram_write_en stays 0.

Source files
------------

// File: rtl/ram_sp_fifo_ctrl.sv
// ram_sp_fifo_ctrl: valid/ready byte FIFO controller in front of a
// single-port RAM (synchronous write, asynchronous read). Each cycle the RAM
// port either takes one push from upstream or does one fetch into the
// registered output stage. A fetch wins over a push.
//
// Optional feature (macro RAM_SP_FIFO_BYPASS_EN): when the RAM holds no words
// and the output register is free, an incoming word goes straight into the
// output register without touching the RAM.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   s_data/s_valid/s_ready   push side
//   m_data/m_valid/m_ready   pop side; m_data/m_valid are registered
//   ram_address/ram_data_in/ram_write_en   drive the RAM port
//   ram_data_out  RAM combinational read data
//   level         words held = words in RAM + m_valid (0..DEPTH+1)
module ram_sp_fifo_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_en,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W:0]   level
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              out_free;
  logic              fetch;
  logic              byp;
  logic              push;

  // Output register can take a new word this cycle.
  assign out_free = !m_valid || m_ready;

  // Refill the output register from the RAM whenever there is something to fetch.
  assign fetch = (cnt != '0) && out_free;

`ifdef RAM_SP_FIFO_BYPASS_EN
  // Empty RAM and free output register: the word skips the RAM entirely.
  assign byp = !rst && (cnt == '0) && out_free && s_valid;
`else
  assign byp = 1'b0;
`endif

  // Push only when the port is not being used for a fetch.
  assign s_ready = !rst && (cnt < CNT_W'(DEPTH)) && !fetch;
  assign push    = s_valid && s_ready && !byp;

  // RAM port drive.
  assign ram_address  = fetch ? rd_ptr : wr_ptr;
  assign ram_data_in  = s_data;
  assign ram_write_en = push;

  assign level = cnt + CNT_W'(m_valid);

  // Pointers, RAM occupancy and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      if (fetch) begin
        m_data  <= ram_data_out;
        m_valid <= 1'b1;
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        cnt     <= cnt - CNT_W'(1);
      end else if (push) begin
        wr_ptr  <= wr_ptr + ADDR_W'(1);
        cnt     <= cnt + CNT_W'(1);
        if (m_valid && m_ready) begin
          m_valid <= 1'b0;
        end
      end else if (byp) begin
        m_data  <= s_data;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        // Word consumed with nothing left to refill from.
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_fifo_ctrl.sv
// Testbench for ram_sp_fifo_ctrl: a behavioural 16x8 RAM plus a queue-based
// reference FIFO. Expected output order and occupancy come from the queue.
module tb_ram_sp_fifo_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_write_en;
  logic [DATA_W-1:0] ram_data_out;
  logic [ADDR_W:0]   level;

  ram_sp_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_en(ram_write_en), .ram_data_out(ram_data_out),
    .level(level)
  );

  // Single-port RAM: synchronous write, asynchronous read.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) if (ram_write_en) mem[ram_address] <= ram_data_in;
  assign ram_data_out = mem[ram_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned       n_vec = 0;
  int unsigned       n_err = 0;
  logic [DATA_W-1:0] q [$];
  logic [DATA_W-1:0] nxt;
  int unsigned       pops;
  int unsigned       accepted;
  bit                last_we;
  bit                last_sready;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, judge handshakes, update model, check level.
  task automatic step(input bit sv, input bit mr);
    bit acc;
    bit pop;
    @(negedge clk);
    s_valid = sv;
    s_data  = nxt;
    m_ready = mr;
    #1;
    acc = s_valid && s_ready;
    pop = m_valid && m_ready;
    last_we     = ram_write_en;
    last_sready = s_ready;
`ifndef RAM_SP_FIFO_BYPASS_EN
    check("ram_we", 32'(ram_write_en), 32'(acc));
`endif
    if (q.size() == DEPTH + 1) check("full_sready", 32'(s_ready), 0);
    if (pop) begin
      if (q.size() == 0) check("pop_empty", 32'(m_valid), 0);
      else begin
        check("m_data", 32'(m_data), 32'(q[0]));
        void'(q.pop_front());
        pops++;
      end
    end
    if (acc) begin
      q.push_back(nxt);
      nxt = nxt + 8'd1;
      accepted++;
    end
    @(posedge clk);
    #1;
    check("level", 32'(level), q.size());
  endtask

  // Reset asserted between clock edges; effects must be immediate.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_level", 32'(level), 0);
    check("rst_we", 32'(ram_write_en), 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b0;
    #1;
    check("post_rst_s_ready", 32'(s_ready), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) step(1'b0, 1'b1);
    check("drain_done", q.size(), 0);
    step(1'b0, 1'b1);
    check("empty_m_valid", 32'(m_valid), 0);
    check("empty_level", 32'(level), 0);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b0; nxt = 8'h01;
    pops = 0; accepted = 0;
    #1;
    check("reset_m_valid", 32'(m_valid), 0);
    check("reset_s_ready", 32'(s_ready), 0);
    check("reset_level", 32'(level), 0);
    check("reset_we", 32'(ram_write_en), 0);
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
    #1;
    check("deassert_s_ready", 32'(s_ready), 1);

    // Fill to total capacity of DEPTH+1 with the consumer stalled.
    nxt = 8'h01; accepted = 0;
    for (int i = 0; i < 60 && accepted < DEPTH + 1; i++) step(1'b1, 1'b0);
    check("fill_accepted", accepted, DEPTH + 1);
    check("full_level", 32'(level), DEPTH + 1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("full_hold_sready", 32'(last_sready), 0);
    check("full_hold_data", 32'(nxt), 32'h12);

    // Drain: 0x01..0x11 in order across the pointer wrap.
    drain();

    // Streaming with both sides always willing.
    nxt = 8'h20; pops = 0;
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
`ifdef RAM_SP_FIFO_BYPASS_EN
    check("stream_rate", 32'(pops >= 38 && pops <= 40), 1);
`else
    check("stream_rate", 32'(pops >= 19 && pops <= 20), 1);
`endif
    drain();

    // Random backpressure, then reset after five outputs.
    nxt = 8'h40; pops = 0; accepted = 0;
    for (int i = 0; i < 300 && pops < 5; i++)
      step(accepted < 10 ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)));
    check("rand_pops", pops, 5);
    mid_reset();
    nxt = 8'hA5; accepted = 0;
    for (int i = 0; i < 10 && accepted == 0; i++) step(1'b1, 1'b0);
    check("a5_accepted", accepted, 1);
    pops = 0;
    drain();
    check("a5_popped", pops, 1);

    // Empty-FIFO latency; bypass path when enabled.
    nxt = 8'h3C;
    step(1'b1, 1'b0);
`ifdef RAM_SP_FIFO_BYPASS_EN
    check("byp_we", 32'(last_we), 0);
    check("byp_m_valid", 32'(m_valid), 1);
    check("byp_m_data", 32'(m_data), 32'h3C);
`else
    check("lat_we", 32'(last_we), 1);
    check("lat_m_valid_1", 32'(m_valid), 0);
    step(1'b0, 1'b0);
    check("lat_m_valid_2", 32'(m_valid), 1);
    check("lat_m_data", 32'(m_data), 32'h3C);
`endif
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
